// File: rtl/bus_endpoint_fifo.sv
// Bus endpoint FIFO pair: a transmit FIFO loaded locally and drained by the bus,
// and a receive FIFO filled by the bus (destination-ID filtered) and drained locally.
// Both FIFOs are first-word-fall-through; all flags derive from registered counts.
module bus_endpoint_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_empty,
  output logic [$clog2(depth):0]     rx_count,
  output logic [15:0]                rx_drop_cnt,
  output logic                       tx_ovf,
  output logic                       rx_ovf
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  // Saturating increment for the filter-reject counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Occupancy update for a write/read pair; simultaneous ops leave it unchanged
  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] c,
                                               input logic wr, input logic rd);
    logic [CW-1:0] n;
    n = c;
    if (wr && !rd) n = c + CW'(1);
    else if (!wr && rd) n = c - CW'(1);
    return n;
  endfunction

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;

  logic       tx_do_pop, tx_do_wr, tx_ovf_evt;
  logic       rx_full, rx_match, rx_acc;
  logic       rx_do_rd, rx_do_wr, rx_ovf_evt, rx_rej;
  logic [7:0] dest;

  assign pndng    = (tx_count != '0);
  assign tx_full  = (tx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);

  assign D_pop   = tx_mem[tx_rp];
  assign rx_data = rx_mem[rx_rp];

  // A full FIFO still accepts a write when its head is consumed in the same cycle
  assign tx_do_pop  = pop && pndng;
  assign tx_do_wr   = tx_wr && (!tx_full || tx_do_pop);
  assign tx_ovf_evt = tx_wr && tx_full && !tx_do_pop;

  assign dest       = D_push[pckg_sz-1 -: 8];
  assign rx_match   = (dest == id) || (dest == broadcast);
  assign rx_acc     = push && rx_match;
  assign rx_rej     = push && !rx_match;
  assign rx_do_rd   = rx_rd && !rx_empty;
  assign rx_do_wr   = rx_acc && (!rx_full || rx_do_rd);
  assign rx_ovf_evt = rx_acc && rx_full && !rx_do_rd;

  // Storage writes; data arrays carry no reset, pointers make stale words invisible
  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wp] <= tx_data;
    if (rx_do_wr) rx_mem[rx_wp] <= D_push;
  end

  // Transmit control: pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (tx_do_wr)   tx_wp <= tx_wp + AW'(1);
      if (tx_do_pop)  tx_rp <= tx_rp + AW'(1);
      tx_count <= count_next(tx_count, tx_do_wr, tx_do_pop);
      if (tx_ovf_evt) tx_ovf <= 1'b1;
    end
  end

  // Receive control: pointers, occupancy, reject counter and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_count    <= '0;
      rx_drop_cnt <= '0;
      rx_ovf      <= 1'b0;
    end else begin
      if (rx_do_wr)   rx_wp <= rx_wp + AW'(1);
      if (rx_do_rd)   rx_rp <= rx_rp + AW'(1);
      rx_count <= count_next(rx_count, rx_do_wr, rx_do_rd);
      if (rx_rej)     rx_drop_cnt <= sat_inc16(rx_drop_cnt);
      if (rx_ovf_evt) rx_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Directed testbench for bus_endpoint_fifo (pckg_sz=16, depth=8, id=8'h02).
module tb_bus_endpoint_fifo;

  logic        clk = 1'b0;
  logic        reset, tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_empty, tx_ovf, rx_ovf;
  logic [3:0]  tx_count, rx_count;
  logic [15:0] D_pop, rx_data, rx_drop_cnt;

  int tests = 0;
  int fails = 0;

  bus_endpoint_fifo #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_count(rx_count), .rx_drop_cnt(rx_drop_cnt),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
    tx_data = '0; D_push = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (tx_count !== 4'd0)  begin fails++; $display("FAIL reset_tx_count got %0d exp 0", tx_count); end
    tests++; if (rx_count !== 4'd0)  begin fails++; $display("FAIL reset_rx_count got %0d exp 0", rx_count); end
    tests++; if (pndng !== 1'b0)     begin fails++; $display("FAIL reset_pndng got %b exp 0", pndng); end
    tests++; if (tx_full !== 1'b0)   begin fails++; $display("FAIL reset_tx_full got %b exp 0", tx_full); end
    tests++; if (rx_empty !== 1'b1)  begin fails++; $display("FAIL reset_rx_empty got %b exp 1", rx_empty); end
    tests++; if (rx_drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop got %h exp 0", rx_drop_cnt); end
    tests++; if ({tx_ovf, rx_ovf} !== 2'b00) begin fails++; $display("FAIL reset_ovf got %b exp 00", {tx_ovf, rx_ovf}); end
  endtask

  task automatic test_tx_basic();
    logic [15:0] words [3];
    words[0] = 16'h01AA; words[1] = 16'h02BB; words[2] = 16'h03CC;
    do_reset();
    tx_wr = 1; tx_data = words[0];
    tick();
    tests++; if (pndng !== 1'b1)     begin fails++; $display("FAIL txb_pndng got %b exp 1", pndng); end
    tests++; if (D_pop !== 16'h01AA) begin fails++; $display("FAIL txb_head got %h exp 01aa", D_pop); end
    for (int i = 1; i < 3; i++) begin
      tx_data = words[i];
      tick();
    end
    tx_wr = 0;
    tests++; if (tx_count !== 4'd3)  begin fails++; $display("FAIL txb_count got %0d exp 3", tx_count); end
    tests++; if (D_pop !== 16'h01AA) begin fails++; $display("FAIL txb_head2 got %h exp 01aa", D_pop); end
    pop = 1;
    for (int i = 1; i < 3; i++) begin
      tick();
      tests++; if (D_pop !== words[i]) begin fails++; $display("FAIL txb_pop%0d got %h exp %h", i, D_pop, words[i]); end
    end
    tick();
    pop = 0;
    tests++; if (pndng !== 1'b0)     begin fails++; $display("FAIL txb_drained_pndng got %b exp 0", pndng); end
    // pop on empty must not disturb anything
    pop = 1;
    tick();
    pop = 0;
    tests++; if (tx_count !== 4'd0)  begin fails++; $display("FAIL txb_empty_pop got %0d exp 0", tx_count); end
  endtask

  task automatic test_tx_full();
    do_reset();
    tx_wr = 1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h0100 + 16'(i);
      tick();
    end
    tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL txf_full got %b exp 1", tx_full); end
    tests++; if (tx_ovf !== 1'b0)  begin fails++; $display("FAIL txf_ovf_early got %b exp 0", tx_ovf); end
    tx_data = 16'h0999;
    tick();
    tx_wr = 0;
    tests++; if (tx_ovf !== 1'b1)    begin fails++; $display("FAIL txf_ovf got %b exp 1", tx_ovf); end
    tests++; if (tx_count !== 4'd8)  begin fails++; $display("FAIL txf_count got %0d exp 8", tx_count); end
    tests++; if (D_pop !== 16'h0100) begin fails++; $display("FAIL txf_head got %h exp 0100", D_pop); end
  endtask

  task automatic test_tx_full_pop();
    do_reset();
    tx_wr = 1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h0100 + 16'(i);
      tick();
    end
    tx_data = 16'h0999; pop = 1;
    tick();
    tx_wr = 0;
    tests++; if (tx_ovf !== 1'b0)   begin fails++; $display("FAIL txfp_ovf got %b exp 0", tx_ovf); end
    tests++; if (tx_count !== 4'd8) begin fails++; $display("FAIL txfp_count got %0d exp 8", tx_count); end
    for (int i = 1; i < 8; i++) begin
      tests++; if (D_pop !== 16'h0100 + 16'(i)) begin fails++; $display("FAIL txfp_drain%0d got %h exp %h", i, D_pop, 16'h0100 + 16'(i)); end
      tick();
    end
    tests++; if (D_pop !== 16'h0999) begin fails++; $display("FAIL txfp_last got %h exp 0999", D_pop); end
    tick();
    pop = 0;
    tests++; if (pndng !== 1'b0) begin fails++; $display("FAIL txfp_empty got %b exp 0", pndng); end
  endtask

  task automatic test_rx_filter();
    do_reset();
    push = 1;
    D_push = 16'h0211; tick();
    D_push = 16'hFF22; tick();
    D_push = 16'h0533; tick();
    push = 0;
    tests++; if (rx_count !== 4'd2)     begin fails++; $display("FAIL rxf_count got %0d exp 2", rx_count); end
    tests++; if (rx_drop_cnt !== 16'd1) begin fails++; $display("FAIL rxf_drop got %0d exp 1", rx_drop_cnt); end
    tests++; if (rx_data !== 16'h0211)  begin fails++; $display("FAIL rxf_head got %h exp 0211", rx_data); end
    rx_rd = 1; tick();
    tests++; if (rx_data !== 16'hFF22)  begin fails++; $display("FAIL rxf_bcast got %h exp ff22", rx_data); end
    tick();
    rx_rd = 0;
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL rxf_empty got %b exp 1", rx_empty); end
    tests++; if (rx_ovf !== 1'b0)   begin fails++; $display("FAIL rxf_ovf got %b exp 0", rx_ovf); end
  endtask

  task automatic test_wrap();
    do_reset();
    tx_wr = 1; tx_data = 16'h0200;
    push = 1;  D_push = 16'h0200;
    tick();
    pop = 1; rx_rd = 1;
    for (int i = 1; i <= 20; i++) begin
      tx_data = 16'h0200 + 16'(i);
      D_push  = 16'h0200 + 16'(i);
      tests++; if (D_pop !== 16'h0200 + 16'(i - 1))   begin fails++; $display("FAIL wrap_tx%0d got %h exp %h", i, D_pop, 16'h0200 + 16'(i - 1)); end
      tests++; if (rx_data !== 16'h0200 + 16'(i - 1)) begin fails++; $display("FAIL wrap_rx%0d got %h exp %h", i, rx_data, 16'h0200 + 16'(i - 1)); end
      tick();
      tests++; if ({tx_count, rx_count} !== 8'h11) begin fails++; $display("FAIL wrap_cnt%0d got %h exp 11", i, {tx_count, rx_count}); end
    end
    tx_wr = 0; push = 0;
    tests++; if (D_pop !== 16'h0214)   begin fails++; $display("FAIL wrap_tx_last got %h exp 0214", D_pop); end
    tests++; if (rx_data !== 16'h0214) begin fails++; $display("FAIL wrap_rx_last got %h exp 0214", rx_data); end
    tick();
    pop = 0; rx_rd = 0;
    tests++; if ({pndng, rx_empty, tx_full, tx_ovf, rx_ovf} !== 5'b01000) begin
      fails++; $display("FAIL wrap_flags got %b exp 01000", {pndng, rx_empty, tx_full, tx_ovf, rx_ovf});
    end
  endtask

  task automatic test_rx_full();
    do_reset();
    push = 1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0240 + 16'(i);
      tick();
    end
    tests++; if (rx_ovf !== 1'b0) begin fails++; $display("FAIL rxo_ovf_early got %b exp 0", rx_ovf); end
    D_push = 16'h02EE;
    tick();
    push = 0;
    tests++; if (rx_ovf !== 1'b1)       begin fails++; $display("FAIL rxo_ovf got %b exp 1", rx_ovf); end
    tests++; if (rx_count !== 4'd8)     begin fails++; $display("FAIL rxo_count got %0d exp 8", rx_count); end
    tests++; if (rx_drop_cnt !== 16'd0) begin fails++; $display("FAIL rxo_drop got %0d exp 0", rx_drop_cnt); end
    rx_rd = 1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (rx_data !== 16'h0240 + 16'(i)) begin fails++; $display("FAIL rxo_drain%0d got %h exp %h", i, rx_data, 16'h0240 + 16'(i)); end
      tick();
    end
    rx_rd = 0;
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL rxo_ninth_present got %b exp 1", rx_empty); end
  endtask

  task automatic test_reset_midtraffic();
    do_reset();
    tx_wr = 1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 16'h0300 + 16'(i);
      push    = (i < 3);
      D_push  = (i < 3) ? 16'h0230 + 16'(i) : 16'h0000;
      tick();
    end
    tx_wr = 0;
    push = 1; D_push = 16'h0700;
    tick();
    push = 0;
    tests++; if ({tx_count, rx_count} !== 8'h53) begin fails++; $display("FAIL mid_pre_counts got %h exp 53", {tx_count, rx_count}); end
    tests++; if (rx_drop_cnt !== 16'd1) begin fails++; $display("FAIL mid_pre_drop got %0d exp 1", rx_drop_cnt); end
    reset = 1; pop = 1; rx_rd = 1;
    tick();
    reset = 0; pop = 0; rx_rd = 0;
    tests++; if ({tx_count, rx_count} !== 8'h00) begin fails++; $display("FAIL mid_counts got %h exp 00", {tx_count, rx_count}); end
    tests++; if ({pndng, rx_empty, tx_full} !== 3'b010) begin fails++; $display("FAIL mid_flags got %b exp 010", {pndng, rx_empty, tx_full}); end
    tests++; if (rx_drop_cnt !== 16'd0) begin fails++; $display("FAIL mid_drop got %0d exp 0", rx_drop_cnt); end
    tick();
    tests++; if ({tx_count, rx_count, pndng, rx_empty} !== 10'b0000_0000_01) begin
      fails++; $display("FAIL mid_settle got %b exp 0000000001", {tx_count, rx_count, pndng, rx_empty});
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    push = 1; D_push = 16'h0500;
    repeat (65534) tick();
    tests++; if (rx_drop_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_fffe got %h exp fffe", rx_drop_cnt); end
    tick();
    tests++; if (rx_drop_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_ffff got %h exp ffff", rx_drop_cnt); end
    tick();
    push = 0;
    tests++; if (rx_drop_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got %h exp ffff", rx_drop_cnt); end
    tests++; if (rx_count !== 4'd0)        begin fails++; $display("FAIL sat_rxcount got %0d exp 0", rx_count); end
  endtask

  initial begin
    reset = 1;
    idle();
    #1;
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_tx_full_pop();
    test_rx_filter();
    test_wrap();
    test_rx_full();
    test_reset_midtraffic();
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_endpoint_fifo.md
Name: bus_endpoint_fifo

Overview:
Device-side endpoint of the bus generator/arbiter interface: the FIFO pair one bus port talks to. The transmit FIFO is loaded by local logic and presents pndng/D_pop to the bus, which drains it with pop. The receive FIFO accepts push/D_push from the bus, filters on destination ID (own ID or broadcast) and is drained by local logic. One instance per bus port (drvrs instances per system).

Parameters:
pckg_sz, 16, packet width in bits; destination ID occupies bits [pckg_sz-1 -: 8]
depth, 8, entries per FIFO (power of two, >=2)
id, 0, this endpoint's 8-bit destination ID
broadcast, 8'hFF, broadcast destination ID

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
tx_wr  in  1  local write strobe into transmit FIFO
tx_data  in  pckg_sz  local write data
tx_full  out  1  transmit FIFO full
tx_count  out  $clog2(depth)+1  transmit occupancy
pndng  out  1  transmit FIFO non-empty (to bus)
D_pop  out  pckg_sz  transmit FIFO head (to bus)
pop  in  1  bus consumes head of transmit FIFO
push  in  1  bus delivers a packet
D_push  in  pckg_sz  delivered packet
rx_rd  in  1  local read strobe from receive FIFO
rx_data  out  pckg_sz  receive FIFO head
rx_empty  out  1  receive FIFO empty
rx_count  out  $clog2(depth)+1  receive occupancy
rx_drop_cnt  out  16  packets rejected by ID filter
tx_ovf  out  1  sticky: tx_wr while full and no pop
rx_ovf  out  1  sticky: accepted push while full and no rx_rd

Behaviour:
- Everything changes only on posedge clk. Reset has priority over all other inputs, takes effect the same edge: pointers=0, counts=0, pndng=0, tx_full=0, rx_empty=1, rx_drop_cnt=0, tx_ovf=0, rx_ovf=0. D_pop/rx_data are don't-care while empty but driven from storage (no X propagation requirement beyond storage contents). A reset mid-traffic discards all stored packets.
- Both FIFOs are first-word-fall-through: D_pop = tx head, rx_data = rx head, combinational from storage/read pointer; a write to an empty FIFO is visible on the head and flags the cycle after the write edge (latency 1).
- pndng = (tx_count != 0); tx_full = (tx_count == depth); rx_empty = (rx_count == 0). All registered-count derived, no combinational path from inputs to flags.
- TX: pop with pndng=1 advances read pointer; pop with pndng=0 ignored (no pointer change, no flag). tx_wr with tx_full=0 stores tx_data. tx_wr with tx_full=1: accepted only if pop asserted the same cycle (count stays depth); otherwise dropped, tx_ovf set.
- Simultaneous tx_wr and pop on non-empty, non-full FIFO: count unchanged, both pointers advance. On empty FIFO: pop ignored, write accepted, count becomes 1.
- RX filter: dest = D_push[pckg_sz-1 -: 8]. push accepted iff dest == id or dest == broadcast. Rejected push: no storage, rx_drop_cnt += 1, saturating at 16'hFFFF.
- Accepted push follows TX rules mirrored: stores if not full; if full, stored only when rx_rd with rx_empty=0 is asserted the same cycle, else dropped and rx_ovf set (rx_drop_cnt unchanged). rx_rd on empty ignored.
- Pointers are $clog2(depth) bits, wrap naturally modulo depth; counts are $clog2(depth)+1 bits, range 0..depth.
- Sticky flags clear only on reset.

Test Plan:
- Reset then 3 tx_wr (16'h01AA, 16'h02BB, 16'h03CC) -> pndng=1 cycle after first write, D_pop=16'h01AA, tx_count=3; 3 pops -> D_pop steps BB, CC, pndng=0 after third.
- Fill tx to depth=8, 9th tx_wr without pop -> tx_full=1, tx_ovf=1, tx_count=8; repeat with pop same cycle -> tx_ovf stays 0 (fresh reset), count stays 8, 9th word later read out last.
- id=8'h02: push 16'h02_11, 16'hFF_22, 16'h05_33 -> rx_count=2, rx_data 16'h0211 then 16'hFF22, rx_drop_cnt=1.
- Wrap-around: 20 write/read pairs through each FIFO at depth 8 with simultaneous rd/wr after first entry -> data order preserved, count constant at 1, no flags.
- rx full (8 accepted) plus 9th accepted push without rx_rd -> rx_ovf=1, rx_count=8, 9th packet absent from drain.
- Reset asserted with tx_count=5, rx_count=3 -> next cycle all counts 0, pndng=0, rx_empty=1, rx_drop_cnt=0; pop/rx_rd during reset have no effect.
